pixel_stream_gen: RTL and testbench

- Source end of the grayscale pixel stream consumed by the edge-filter stage.
- Generates 640x480 VGA-style timing and reads pixels from a synchronous frame buffer.
- Emits de / x_coor / y_coor / g_data, all aligned, plus active-low hsync/vsync.
- Sits between the frame-buffer read port and the filter/display chain.

---
 rtl/pixel_stream_if.sv | 29 ++
 rtl/pixel_stream_gen.sv | 196 +++++++++++++++++++
 tb/tb_pixel_stream_gen.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_if.sv
// Pixel stream bus: frame-buffer read port plus the aligned video output stream.
//   master (generator): drives rd_en, rd_addr, de, x_coor, y_coor, g_data,
//                       hsync, vsync, frame_start; receives rd_data
//   slave  (memory/sink): the mirror image
// Parameter: ADDR_W - frame-buffer address width.
interface pixel_stream_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       rd_data;
  logic              de;
  logic [9:0]        x_coor;
  logic [8:0]        y_coor;
  logic [11:0]       g_data;
  logic              hsync;
  logic              vsync;
  logic              frame_start;

  modport master (
    output rd_en, rd_addr, de, x_coor, y_coor, g_data, hsync, vsync, frame_start,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, de, x_coor, y_coor, g_data, hsync, vsync, frame_start,
    output rd_data
  );
endinterface

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: VGA-style timing generator and frame-buffer reader that
// sources the grayscale pixel stream for the edge-filter chain.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   pix_en      - pixel tick; counters and outputs advance only on it
//   run         - level; high streams frames, low finishes the current frame
//   busy        - high while streaming or draining
//   bus         - pixel_stream_if.master: rd_en/rd_addr/rd_data read port and
//                 de/x_coor/y_coor/g_data/hsync/vsync/frame_start output stream
// Build option: define TEST_PATTERN_EN to replace frame-buffer data with an
// x/y checkerboard pattern (rd_en held low, rd_data ignored).
// Pipeline: a pix_en tick samples the counters into a holding stage and issues
// the read; the clk after the tick moves that stage to the outputs together
// with the returned read data, so de/coords/syncs/g_data always line up.
module pixel_stream_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           run,
  output logic           busy,
  pixel_stream_if.master bus
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic             running;
  logic             wrap;
  logic             in_active;
  logic             rd_req;

  // Holding stage filled on each pix_en tick
  logic             tick_d;
  logic             s_de;
  logic [X_W-1:0]   s_x;
  logic [Y_W-1:0]   s_y;
  logic             s_hs;
  logic             s_vs;
  logic             s_first;
  logic [11:0]      pixel;

  assign running   = (state != IDLE);
  assign wrap      = pix_en & (h_cnt == H_LAST) & (v_cnt == V_LAST);
  assign in_active = running & (h_cnt < H_ACT_END) & (v_cnt < V_ACT_END);
  assign rd_req    = pix_en & in_active;
  assign bus.rd_addr = rd_addr;

`ifdef TEST_PATTERN_EN
  logic [3:0] pattern;
  logic       unused_rd_data;
  assign pattern        = s_x[5:2] ^ s_y[5:2];
  assign pixel          = {3{pattern}};
  assign bus.rd_en      = 1'b0;
  assign unused_rd_data = ^bus.rd_data;
`else
  assign pixel     = bus.rd_data;
  assign bus.rd_en = rd_req;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Next state: a dropped run lets the frame finish; run again resumes seamlessly
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (run) state_next = ACTIVE;
      end
      ACTIVE, DRAIN: begin
        if (run)       state_next = ACTIVE;
        else if (wrap) state_next = IDLE;
        else           state_next = DRAIN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster counters, parked at 0 while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // Linear read address; wraps after the last active pixel so it never exceeds it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
    end else if (!running || wrap) begin
      rd_addr <= '0;
    end else if (rd_req) begin
      rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + ADDR_W'(1);
    end
  end

  // Holding stage: what the outputs will show for this tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d  <= 1'b0;
      s_de    <= 1'b0;
      s_x     <= '0;
      s_y     <= '0;
      s_hs    <= 1'b1;
      s_vs    <= 1'b1;
      s_first <= 1'b0;
    end else begin
      tick_d <= pix_en;
      if (pix_en) begin
        s_de    <= in_active;
        s_x     <= X_W'(h_cnt);
        s_y     <= Y_W'(v_cnt);
        s_hs    <= ~(running & (h_cnt >= HS_BEG) & (h_cnt <= HS_END));
        s_vs    <= ~(running & (v_cnt >= VS_BEG) & (v_cnt <= VS_END));
        s_first <= in_active & (h_cnt == '0) & (v_cnt == '0);
      end
    end
  end

  // Output stage: one clk after the tick, when the read data has returned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.de          <= 1'b0;
      bus.x_coor      <= '0;
      bus.y_coor      <= '0;
      bus.g_data      <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= tick_d & s_first;
      if (tick_d) begin
        bus.de     <= s_de;
        bus.hsync  <= s_hs;
        bus.vsync  <= s_vs;
        bus.g_data <= s_de ? pixel : '0;
        if (s_de) begin
          bus.x_coor <= s_x;
          bus.y_coor <= s_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Testbench for pixel_stream_gen. Horizontal timing is the real 800-tick line;
// the frame is shortened to 6 active lines (12 total, vsync on lines 8-9) so a
// full frame fits in a short run. Frame-buffer model returns rd_data = addr[11:0].
// The reference model tracks the frame position of each pix_en tick and derives
// every output from the raster rules; the outputs of a tick are visible from
// the clk after that tick.
module tb_pixel_stream_gen;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 6;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 2;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          FRAME    = H_TOTAL * V_TOTAL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic run = 1'b0;
  logic busy;

  pixel_stream_if #(.ADDR_W(19)) bus ();

  pixel_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .ADDR_W(19)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .run(run),
    .busy(busy),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: one-clk read latency, data held between reads
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= bus.rd_addr[11:0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      if (n_fail >= 200) begin
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  endtask

  function automatic logic [11:0] pixel_value(input int h, input int v);
`ifdef TEST_PATTERN_EN
    logic [3:0] t;
    t = 4'((h >> 2) ^ (v >> 2));
    return {t, t, t};
`else
    return 12'(v * H_ACTIVE + h);
`endif
  endfunction

  // ---------------- reference model ----------------
  int          m_pos  = 0;
  bit          m_busy = 1'b0;
  bit          p_valid = 1'b0;
  bit          p_de, p_hs, p_vs, p_first;
  logic [9:0]  p_x;
  logic [8:0]  p_y;
  logic [11:0] p_g;
  logic        e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_fs = 1'b0;
  logic [9:0]  e_x = '0;
  logic [8:0]  e_y = '0;
  logic [11:0] e_g = '0;
  int          mh, mv;
  bit          mact, meof;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos = 0; m_busy = 1'b0; p_valid = 1'b0;
      e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
      e_x = '0; e_y = '0; e_g = '0;
    end else begin
      // previous tick becomes visible
      e_fs = 1'b0;
      if (p_valid) begin
        e_de = p_de; e_hs = p_hs; e_vs = p_vs;
        e_g  = p_de ? p_g : 12'h000;
        if (p_de) begin e_x = p_x; e_y = p_y; end
        e_fs = p_first;
      end
      // this tick
      p_valid = pix_en;
      mh = m_pos % H_TOTAL;
      mv = m_pos / H_TOTAL;
      mact = m_busy && (mh < H_ACTIVE) && (mv < V_ACTIVE);
      if (pix_en) begin
        p_de    = mact;
        p_x     = 10'(mh);
        p_y     = 9'(mv);
        p_g     = pixel_value(mh, mv);
        p_hs    = !(m_busy && mh >= 656 && mh <= 751);
        p_vs    = !(m_busy && mv >= V_ACTIVE + V_FP && mv < V_ACTIVE + V_FP + V_SYNC);
        p_first = mact && (m_pos == 0);
      end
      meof = m_busy && pix_en && (m_pos == FRAME - 1);
      if (m_busy && pix_en) m_pos = (m_pos + 1) % FRAME;
      m_busy = run || (m_busy && !meof);
    end
  end

  // ---------------- compare process ----------------
  int   cnt_de = 0, cnt_hs = 0, cnt_vs = 0, cnt_fs = 0;
  bit   sparse = 1'b0;
  logic prev_rd_en = 1'b0;
  int   ch, cv;
  bit   exp_rd;

  always @(negedge clk) begin
    ch = m_pos % H_TOTAL;
    cv = m_pos / H_TOTAL;
`ifdef TEST_PATTERN_EN
    exp_rd = 1'b0;
`else
    exp_rd = m_busy && pix_en && !reset && (ch < H_ACTIVE) && (cv < V_ACTIVE);
`endif
    chk("de", bus.de, e_de);
    chk("x_coor", bus.x_coor, e_x);
    chk("y_coor", bus.y_coor, e_y);
    chk("g_data", bus.g_data, e_g);
    chk("hsync", bus.hsync, e_hs);
    chk("vsync", bus.vsync, e_vs);
    chk("frame_start", bus.frame_start, e_fs);
    chk("busy", busy, m_busy);
    chk("rd_en", bus.rd_en, exp_rd);
    if (exp_rd) chk("rd_addr", bus.rd_addr, 32'(cv * H_ACTIVE + ch));
    if (sparse) chk("rd_en_width", bus.rd_en & prev_rd_en, 0);
`ifdef TEST_PATTERN_EN
    if (e_de && e_x == 10'd4 && e_y == 9'd0) chk("g_4_0", bus.g_data, 12'h111);
    if (e_de && e_x == 10'd4 && e_y == 9'd4) chk("g_4_4", bus.g_data, 12'h000);
`else
    if (e_de && e_x == 10'd639 && e_y == 9'd0) chk("g_639_0", bus.g_data, 12'h27F);
    if (e_de && e_x == 10'd0 && e_y == 9'd1) chk("g_0_1", bus.g_data, 12'h280);
`endif
    if (e_fs) begin
      chk("fs_x", bus.x_coor, 0);
      chk("fs_y", bus.y_coor, 0);
      chk("fs_g", bus.g_data, 0);
    end
    prev_rd_en = bus.rd_en;
    if (!reset) begin
      cnt_de += int'(bus.de);
      cnt_hs += int'(!bus.hsync);
      cnt_vs += int'(!bus.vsync);
      cnt_fs += int'(bus.frame_start);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; pix_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  bit got;

  initial begin
    // A: continuous pix_en, one full frame
    do_reset();
    run = 1'b1; pix_en = 1'b1;
    tick();
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    repeat (FRAME + 1) tick();
    chk("de_per_frame", cnt_de, H_ACTIVE * V_ACTIVE);
    chk("hsync_low_ticks", cnt_hs, H_SYNC * V_TOTAL);
    chk("vsync_low_ticks", cnt_vs, V_SYNC * H_TOTAL);
    chk("frame_start_per_frame", cnt_fs, 1);
    repeat (20) tick();

    // B: pix_en every 4th clk
    do_reset();
    sparse = 1'b1; run = 1'b1;
    for (int i = 0; i < 4 * 900; i++) begin
      pix_en = (i % 4 == 0);
      tick();
    end
    sparse = 1'b0;

    // C: run dropped at (100,2), drain, idle, then re-raise during drain
    do_reset();
    run = 1'b1; pix_en = 1'b1;
    for (int i = 0; i < FRAME && m_pos != 2 * H_TOTAL + 100; i++) tick();
    run = 1'b0;
    repeat (FRAME) tick();
    chk("idle_busy", busy, 0);
    chk("idle_de", bus.de, 0);
    chk("idle_hsync", bus.hsync, 1);
    chk("idle_vsync", bus.vsync, 1);
    repeat (50) tick();
    run = 1'b1;
    for (int i = 0; i < FRAME && m_pos != 300; i++) tick();
    run = 1'b0;
    for (int i = 0; i < FRAME && m_pos != 5000; i++) tick();
    run = 1'b1;
    cnt_fs = 0;
    repeat (FRAME - 5000 + 50) tick();
    chk("rerun_frame_start", cnt_fs, 1);
    chk("rerun_busy", busy, 1);

    // D: reset mid-line, then restart
    do_reset();
    run = 1'b1; pix_en = 1'b1;
    repeat (300) tick();
    reset = 1'b1;
    #1;
    chk("rst_de", bus.de, 0);
    chk("rst_x", bus.x_coor, 0);
    chk("rst_g", bus.g_data, 0);
    chk("rst_hsync", bus.hsync, 1);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (bus.de) got = 1'b1;
    end
    chk("restart_seen", got, 1);
    if (got) begin
      chk("restart_x", bus.x_coor, 0);
      chk("restart_y", bus.y_coor, 0);
      chk("restart_fs", bus.frame_start, 1);
    end
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
